// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Iterative radix-2 restoring divide/remainder unit for the RV32M
//            DIV, DIVU, REM and REMU operations. It stalls the pipeline with
//            oBusy and pulses oReady for one cycle when oResult is valid.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int         DATA_WIDTH = 32,
    parameter int         CNT_WIDTH  = 6,
    parameter logic [4:0] OPDIV      = 5'b01100,
    parameter logic [4:0] OPDIVU     = 5'b01101,
    parameter logic [4:0] OPREM      = 5'b01110,
    parameter logic [4:0] OPREMU     = 5'b01111
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iStart,
    input  logic                  iFlush,
    input  logic [4:0]            iControlSignal,
    input  logic [DATA_WIDTH-1:0] iA,
    input  logic [DATA_WIDTH-1:0] iB,
    output logic [DATA_WIDTH-1:0] oResult,
    output logic                  oBusy,
    output logic                  oReady
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH-1:0] c_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] c_MIN  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]  c_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                r_state_q,   w_state_d;
    logic [DATA_WIDTH-1:0] r_quo_q,     w_quo_d;
    logic [DATA_WIDTH-1:0] r_rem_q,     w_rem_d;
    logic [DATA_WIDTH-1:0] r_dvsr_q,    w_dvsr_d;
    logic [DATA_WIDTH-1:0] r_spec_q,    w_spec_d;
    logic [DATA_WIDTH-1:0] r_result_q,  w_result_d;
    logic [CNT_WIDTH-1:0]  r_cnt_q,     w_cnt_d;
    logic                  r_is_rem_q,  w_is_rem_d;
    logic                  r_neg_quo_q, w_neg_quo_d;
    logic                  r_neg_rem_q, w_neg_rem_d;
    logic                  r_special_q, w_special_d;

    // Operation decode and operand preparation at the acceptance point
    logic                  w_is_div_op;
    logic                  w_signed_op;
    logic                  w_rem_op;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic                  w_div_zero;
    logic                  w_overflow;
    logic [DATA_WIDTH-1:0] w_spec_val;
    logic                  w_accept;

    // Iteration and sign-fix datapath
    logic [DATA_WIDTH+1:0] w_trial;
    logic                  w_trial_neg;
    logic [DATA_WIDTH-1:0] w_quo_fix;
    logic [DATA_WIDTH-1:0] w_rem_fix;

    // Decode the request and precompute magnitudes and special-case results
    always_comb begin
        w_is_div_op = (iControlSignal == OPDIV)  || (iControlSignal == OPDIVU) ||
                      (iControlSignal == OPREM)  || (iControlSignal == OPREMU);
        w_signed_op = (iControlSignal == OPDIV)  || (iControlSignal == OPREM);
        w_rem_op    = (iControlSignal == OPREM)  || (iControlSignal == OPREMU);
        w_a_neg     = w_signed_op && iA[DATA_WIDTH-1];
        w_b_neg     = w_signed_op && iB[DATA_WIDTH-1];
        w_a_mag     = w_a_neg ? (~iA + 1'b1) : iA;
        w_b_mag     = w_b_neg ? (~iB + 1'b1) : iB;
        w_div_zero  = (iB == '0);
        w_overflow  = w_signed_op && (iA == c_MIN) && (iB == c_ONES);
        if (w_div_zero) begin
            w_spec_val = w_rem_op ? iA : c_ONES;
        end else begin
            w_spec_val = w_rem_op ? '0 : c_MIN;
        end
        w_accept    = ((r_state_q == S_IDLE) || (r_state_q == S_DONE)) &&
                      iStart && !iFlush && w_is_div_op;
    end

    // One restoring step: shift {rem, quo} left and trial-subtract the divisor
    always_comb begin
        w_trial     = {1'b0, r_rem_q, r_quo_q[DATA_WIDTH-1]} - {2'b00, r_dvsr_q};
        w_trial_neg = w_trial[DATA_WIDTH+1];
        w_quo_fix   = r_neg_quo_q ? (~r_quo_q + 1'b1) : r_quo_q;
        w_rem_fix   = r_neg_rem_q ? (~r_rem_q + 1'b1) : r_rem_q;
    end

    // Next-state and datapath control; flush overrides everything else
    always_comb begin
        w_state_d   = r_state_q;
        w_quo_d     = r_quo_q;
        w_rem_d     = r_rem_q;
        w_dvsr_d    = r_dvsr_q;
        w_spec_d    = r_spec_q;
        w_result_d  = r_result_q;
        w_cnt_d     = r_cnt_q;
        w_is_rem_d  = r_is_rem_q;
        w_neg_quo_d = r_neg_quo_q;
        w_neg_rem_d = r_neg_rem_q;
        w_special_d = r_special_q;

        if (iFlush) begin
            w_state_d = S_IDLE;
        end else if (w_accept) begin
            w_quo_d     = w_a_mag;
            w_rem_d     = '0;
            w_dvsr_d    = w_b_mag;
            w_cnt_d     = '0;
            w_is_rem_d  = w_rem_op;
            w_neg_quo_d = w_a_neg ^ w_b_neg;
            w_neg_rem_d = w_a_neg;
            w_special_d = w_div_zero || w_overflow;
            w_spec_d    = w_spec_val;
            w_state_d   = (w_div_zero || w_overflow) ? S_FIX : S_CALC;
        end else begin
            case (r_state_q)
                S_CALC: begin
                    if (w_trial_neg) begin
                        w_rem_d = {r_rem_q[DATA_WIDTH-2:0], r_quo_q[DATA_WIDTH-1]};
                    end else begin
                        w_rem_d = w_trial[DATA_WIDTH-1:0];
                    end
                    w_quo_d = {r_quo_q[DATA_WIDTH-2:0], ~w_trial_neg};
                    w_cnt_d = r_cnt_q + 1'b1;
                    if (r_cnt_q == c_LAST) begin
                        w_state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_special_q) begin
                        w_result_d = r_spec_q;
                    end else begin
                        w_result_d = r_is_rem_q ? w_rem_fix : w_quo_fix;
                    end
                    w_state_d = S_DONE;
                end
                S_DONE: begin
                    w_state_d = S_IDLE;
                end
                default: begin
                    w_state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state_q   <= S_IDLE;
            r_quo_q     <= '0;
            r_rem_q     <= '0;
            r_dvsr_q    <= '0;
            r_spec_q    <= '0;
            r_result_q  <= '0;
            r_cnt_q     <= '0;
            r_is_rem_q  <= 1'b0;
            r_neg_quo_q <= 1'b0;
            r_neg_rem_q <= 1'b0;
            r_special_q <= 1'b0;
        end else begin
            r_state_q   <= w_state_d;
            r_quo_q     <= w_quo_d;
            r_rem_q     <= w_rem_d;
            r_dvsr_q    <= w_dvsr_d;
            r_spec_q    <= w_spec_d;
            r_result_q  <= w_result_d;
            r_cnt_q     <= w_cnt_d;
            r_is_rem_q  <= w_is_rem_d;
            r_neg_quo_q <= w_neg_quo_d;
            r_neg_rem_q <= w_neg_rem_d;
            r_special_q <= w_special_d;
        end
    end

    // Status outputs decode directly from state so reset clears them at once
    always_comb begin
        oResult = r_result_q;
        oBusy   = (r_state_q == S_CALC) || (r_state_q == S_FIX);
        oReady  = (r_state_q == S_DONE);
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Brief    : Self-checking bench for div_unit: directed vector table, random
//            operations against an arithmetic reference model, and hand-written
//            control sequences (ignored start, flush, async reset, back-to-back).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    localparam logic [4:0] c_OPDIV  = 5'b01100;
    localparam logic [4:0] c_OPDIVU = 5'b01101;
    localparam logic [4:0] c_OPREM  = 5'b01110;
    localparam logic [4:0] c_OPREMU = 5'b01111;
    localparam logic [4:0] c_OPADD  = 5'b00000;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iStart = 1'b0;
    logic        iFlush = 1'b0;
    logic [4:0]  iControlSignal = 5'd0;
    logic [31:0] iA = 32'd0;
    logic [31:0] iB = 32'd0;
    logic [31:0] oResult;
    logic        oBusy;
    logic        oReady;

    int n_checks = 0;
    int n_errors = 0;

    div_unit #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (6),
        .OPDIV      (c_OPDIV),
        .OPDIVU     (c_OPDIVU),
        .OPREM      (c_OPREM),
        .OPREMU     (c_OPREMU)
    ) dut (
        .iCLK           (iCLK),
        .iRST           (iRST),
        .iStart         (iStart),
        .iFlush         (iFlush),
        .iControlSignal (iControlSignal),
        .iA             (iA),
        .iB             (iB),
        .oResult        (oResult),
        .oBusy          (oBusy),
        .oReady         (oReady)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RISC-V M-extension results from plain arithmetic
    function automatic logic [31:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        bit sgn = (op == c_OPDIV) || (op == c_OPREM);
        bit rem = (op == c_OPREM) || (op == c_OPREMU);
        if (b == 32'd0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'd0 : 32'h8000_0000;
        if (sgn) return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return rem ? (a % b) : (a / b);
    endfunction

    function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bit sgn = (op == c_OPDIV) || (op == c_OPREM);
        if (b == 32'd0) return 2;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Present a request now, let the next edge accept it, then scramble inputs
    task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        iStart = 1'b1;
        iControlSignal = op;
        iA = a;
        iB = b;
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        iA = $urandom;
        iB = $urandom;
        iControlSignal = 5'($urandom);
    endtask

    // Latency counts the acceptance cycle as cycle 1
    task automatic wait_ready(output int lat, output int busy);
        lat = 1;
        busy = 0;
        while (!oReady && lat < 100) begin
            if (oBusy) busy++;
            @(posedge iCLK);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat, busy, bad;
        logic [31:0] prev, a, b, exp;
        logic [4:0] op;
        logic [4:0] ops[4];
        ops[0] = c_OPDIV; ops[1] = c_OPDIVU; ops[2] = c_OPREM; ops[3] = c_OPREMU;

        vecs[0]  = '{c_OPDIVU, 32'd100,        32'd7,          32'd14,         34};
        vecs[1]  = '{c_OPREMU, 32'd100,        32'd7,          32'd2,          34};
        vecs[2]  = '{c_OPDIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
        vecs[3]  = '{c_OPREM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
        vecs[4]  = '{c_OPREM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34};
        vecs[5]  = '{c_OPDIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  2};
        vecs[6]  = '{c_OPREMU, 32'd5,          32'd0,          32'd5,          2};
        vecs[7]  = '{c_OPDIV,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  2};
        vecs[8]  = '{c_OPDIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  2};
        vecs[9]  = '{c_OPREM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          2};
        vecs[10] = '{c_OPDIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};

        // Reset state
        #12;
        check("reset_result", oResult, 32'd0);
        check("reset_busy", {31'd0, oBusy}, 32'd0);
        check("reset_ready", {31'd0, oReady}, 32'd0);
        @(negedge iCLK);
        iRST = 1'b0;

        // Directed vectors
        for (int i = 0; i < 11; i++) begin
            @(negedge iCLK);
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_ready(lat, busy);
            check($sformatf("vec%0d_result", i), oResult, vecs[i].exp_res);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (i == 0) check("vec0_busy_cycles", 32'(busy), 32'd33);
        end

        // Random operations against the reference model
        for (int i = 0; i < 30; i++) begin
            op = ops[$urandom_range(0, 3)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: b = b >> $urandom_range(1, 31);
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(posedge iCLK);
            @(negedge iCLK);
            start_op(op, a, b);
            wait_ready(lat, busy);
            check($sformatf("rand%0d_result", i), oResult, ref_model(op, a, b));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(ref_lat(op, a, b)));
        end

        // Start with a non-divide code must be ignored
        repeat (3) @(posedge iCLK);
        prev = oResult;
        @(negedge iCLK);
        start_op(c_OPADD, 32'd9, 32'd3);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (oBusy || oReady) bad++;
            @(posedge iCLK);
            #1;
        end
        check("opadd_no_activity", 32'(bad), 32'd0);
        check("opadd_result_held", oResult, prev);

        // Start pulsed in CALC cycle 5 is ignored
        @(negedge iCLK);
        start_op(c_OPDIVU, 32'd1000, 32'd10);
        repeat (4) @(posedge iCLK);
        #1;
        iStart = 1'b1;
        iControlSignal = c_OPREMU;
        iA = 32'd77;
        iB = 32'd0;
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        wait_ready(lat, busy);
        check("calc_start_result", oResult, 32'd100);
        check("calc_start_latency", 32'(lat + 5), 32'd34);

        // Flush in CALC cycle 10 aborts without oReady
        prev = oResult;
        @(negedge iCLK);
        start_op(c_OPDIV, 32'hFFFF_FF00, 32'd3);
        repeat (9) @(posedge iCLK);
        #1;
        iFlush = 1'b1;
        @(posedge iCLK);
        #1;
        iFlush = 1'b0;
        check("flush_busy", {31'd0, oBusy}, 32'd0);
        check("flush_result_held", oResult, prev);
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (oBusy || oReady) bad++;
            @(posedge iCLK);
            #1;
        end
        check("flush_no_ready", 32'(bad), 32'd0);

        // Back-to-back: new request accepted in the DONE cycle
        @(negedge iCLK);
        start_op(c_OPDIVU, 32'd1000, 32'd3);
        wait_ready(lat, busy);
        check("b2b_first_result", oResult, 32'd333);
        start_op(c_OPDIV, 32'hFFFF_FF9C, 32'd7);
        wait_ready(lat, busy);
        check("b2b_second_result", oResult, 32'hFFFF_FFF2);
        check("b2b_second_latency", 32'(lat), 32'd34);

        // Asynchronous reset between edges in mid-CALC
        @(negedge iCLK);
        start_op(c_OPREMU, 32'd55, 32'd10);
        repeat (5) @(posedge iCLK);
        #2;
        iRST = 1'b1;
        #1;
        check("async_rst_result", oResult, 32'd0);
        check("async_rst_busy", {31'd0, oBusy}, 32'd0);
        check("async_rst_ready", {31'd0, oReady}, 32'd0);
        @(negedge iCLK);
        iRST = 1'b0;

        // Recovery after reset
        @(negedge iCLK);
        start_op(c_OPREMU, 32'd55, 32'd10);
        wait_ready(lat, busy);
        check("post_rst_result", oResult, 32'd5);
        check("post_rst_latency", 32'(lat), 32'd34);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
